mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk (posedge) and rst.
REQ-002 Parameters (name, default, meaning), one per line:
- WORD_W, 32, word width.
- ADDR_W, 15, word address width.
- BLOCK_WORDS, 4, words per cache block.
- LATENCY, 4, access-wait cycles before the first word read.
REQ-003 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, clock.
- rst, in, 1, synchronous reset.
- read, in, 1, block read request; the cache controller holds it until done.
- addr, in, ADDR_W, word address of the request.
- wr_en, in, 1, single-word write strobe.
- wr_addr, in, ADDR_W, write address.
- wr_data, in, WORD_W, write data.
- data_out, out, WORD_W*BLOCK_WORDS, returned block; word0 in the LSBs.
- done, out, 1, one-cycle block-valid pulse.
- busy, out, 1, request in progress.

Function
REQ-004 States SHALL be IDLE, WAIT, FETCH and DONE.
REQ-005 Request acceptance SHALL occur only in IDLE, on a rising read (read=1 and the previous-cycle read=0).
REQ-006 At the acceptance edge, the block SHALL latch base = addr with its low log2(BLOCK_WORDS) bits cleared, and go to WAIT.
REQ-007 WAIT SHALL last exactly LATENCY cycles, then go to FETCH.
REQ-008 FETCH SHALL read one word per cycle, base+0 .. base+BLOCK_WORDS-1 in order, into data_out lane i, then go to DONE.
REQ-009 done SHALL be high for exactly the cycle starting at acceptance edge + LATENCY + BLOCK_WORDS (+8 at defaults), then the block SHALL return to IDLE.
REQ-010 data_out SHALL hold its value after done until the next acceptance; it is undefined while busy.
REQ-011 busy SHALL be 1 in WAIT, FETCH and DONE, and 0 in IDLE.
REQ-012 read deasserting mid-request SHALL NOT abort it; done still pulses.
REQ-013 read still high after done SHALL NOT retrigger; it must fall before a new request is accepted.
REQ-014 wr_en SHALL write mem[wr_addr] = wr_data at the clock edge only when in IDLE; it is ignored (dropped) when busy.
REQ-015 A write and an acceptance on the same edge SHALL both take effect; the fetch returns post-write data.
REQ-016 Block addresses SHALL be aligned, so base+i never wraps past 2^ADDR_W-1; addr low bits are ignored.

Reset
REQ-017 rst SHALL force IDLE, done=0, busy=0, data_out=0, and the previous-read register to 0.
REQ-018 rst mid-request SHALL cancel the request with no done pulse.
REQ-019 Memory contents SHALL NOT be cleared by rst; the simulation initial contents are loaded from a hex file.

Structure
REQ-020 Shared package mem_pkg SHALL hold WORD_W, ADDR_W, BLOCK_WORDS, LATENCY defaults and the state enum.
REQ-021 Sub-module mem_array SHALL be a 2^ADDR_W x WORD_W array with one synchronous write port and one asynchronous read port; mem_responder holds the FSM, counters and data_out register.

Verification
REQ-022 The bench SHALL cover these directed scenarios at default parameters:
- Preload mem[0x100..0x103] = 0xA0..0xA3; rise read with addr=0x102 at edge T -> done only at T+8, data_out = {A3,A2,A1,A0}, busy high T..T+8.
- Hold read high for 3 cycles after done -> no second done, busy stays 0.
- wr_en to 0x200 during busy -> mem[0x200] unchanged; wr_en in IDLE with the same edge as a read rise at 0x200 -> the new word appears in lane 0.
- rst pulsed at T+3 of a request -> no done, busy=0 and data_out=0 next cycle; a fresh read is accepted normally.
- Drop read one cycle after acceptance -> done still at T+8 with correct data.
- addr=0x7FFF -> words 0x7FFC..0x7FFF returned; no wrap.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared defaults and FSM state type for the block-read memory responder
package mem_pkg;

    localparam int MEM_WORD_W      = 32;
    localparam int MEM_ADDR_W      = 15;
    localparam int MEM_BLOCK_WORDS = 4;
    localparam int MEM_LATENCY     = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_FETCH,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - word array with one synchronous write port and one asynchronous read port
module mem_array
    import mem_pkg::*;
#(
    parameter int WORD_W = MEM_WORD_W,
    parameter int ADDR_W = MEM_ADDR_W
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    // Contents survive reset; nothing here clears them.
    logic [WORD_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - block-read responder: waits LATENCY cycles, then fetches an aligned block one word per cycle
module mem_responder
    import mem_pkg::*;
#(
    parameter int WORD_W      = MEM_WORD_W,
    parameter int ADDR_W      = MEM_ADDR_W,
    parameter int BLOCK_WORDS = MEM_BLOCK_WORDS,
    parameter int LATENCY     = MEM_LATENCY
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          read,
    input  logic [ADDR_W-1:0]             addr,
    input  logic                          wr_en,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [WORD_W-1:0]             wr_data,
    output logic [WORD_W*BLOCK_WORDS-1:0] data_out,
    output logic                          done,
    output logic                          busy
);

    localparam int CNT_MAX = (LATENCY > BLOCK_WORDS) ? LATENCY : BLOCK_WORDS;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0]  LAST_WAIT  = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0]  LAST_FETCH = CNT_W'(BLOCK_WORDS - 1);
    localparam logic [ADDR_W-1:0] OFF_MASK   = ADDR_W'(BLOCK_WORDS - 1);

    state_t            state;
    state_t            state_next;
    logic              prev_read;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] rd_addr;
    logic [WORD_W-1:0] rd_data;
    logic              accept;
    logic              mem_wr;

    // Only a rising read is a new request; a level held across done is ignored.
    assign accept  = (state == ST_IDLE) && read && !prev_read;
    assign mem_wr  = wr_en && (state == ST_IDLE);
    assign rd_addr = base + ADDR_W'(cnt);
    assign done    = (state == ST_DONE);
    assign busy    = (state != ST_IDLE);

    mem_array #(
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W)
    ) u_mem_array (
        .clk     (clk),
        .wr_en   (mem_wr),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (accept) state_next = ST_WAIT;
            ST_WAIT:  if (cnt == LAST_WAIT) state_next = ST_FETCH;
            ST_FETCH: if (cnt == LAST_FETCH) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_read <= 1'b0;
            cnt       <= '0;
            base      <= '0;
            data_out  <= '0;
        end else begin
            prev_read <= read;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (accept) begin
                        base <= addr & ~OFF_MASK;
                    end
                end
                ST_WAIT: begin
                    cnt <= (cnt == LAST_WAIT) ? '0 : cnt + 1'b1;
                end
                ST_FETCH: begin
                    data_out[int'(cnt)*WORD_W +: WORD_W] <= rd_data;
                    cnt <= cnt + 1'b1;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized and directed self-checking bench for mem_responder against a word-level memory model
module tb_mem_responder;

    localparam int WORD_W      = 32;
    localparam int ADDR_W      = 15;
    localparam int BLOCK_WORDS = 4;
    localparam int LATENCY     = 4;
    localparam int DONE_AT     = LATENCY + BLOCK_WORDS;
    localparam int WATCH       = DONE_AT + 4;

    logic                          clk = 1'b0;
    logic                          rst = 1'b1;
    logic                          read = 1'b0;
    logic [ADDR_W-1:0]             addr = '0;
    logic                          wr_en = 1'b0;
    logic [ADDR_W-1:0]             wr_addr = '0;
    logic [WORD_W-1:0]             wr_data = '0;
    logic [WORD_W*BLOCK_WORDS-1:0] data_out;
    logic                          done;
    logic                          busy;

    int tests = 0;
    int fails = 0;
    int edge_cnt = 0;
    int acc_edge = 0;
    bit acc_valid = 0;

    logic [WORD_W-1:0] ref_mem [logic [ADDR_W-1:0]];

    mem_responder #(
        .WORD_W      (WORD_W),
        .ADDR_W      (ADDR_W),
        .BLOCK_WORDS (BLOCK_WORDS),
        .LATENCY     (LATENCY)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .read     (read),
        .addr     (addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .data_out (data_out),
        .done     (done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock edge; the model applies a write unless the responder is busy at that edge.
    task automatic step();
        logic              w;
        logic              r;
        logic [ADDR_W-1:0] a;
        logic [WORD_W-1:0] d;
        w = wr_en; r = rst; a = wr_addr; d = wr_data;
        @(posedge clk);
        edge_cnt++;
        if (r) begin
            acc_valid = 0;
        end else if (w && !(acc_valid && edge_cnt > acc_edge && edge_cnt <= acc_edge + DONE_AT + 1)) begin
            ref_mem[a] = d;
        end
        #1;
    endtask

    task automatic write_word(input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    function automatic logic [WORD_W*BLOCK_WORDS-1:0] model_block(input logic [ADDR_W-1:0] a);
        logic [WORD_W*BLOCK_WORDS-1:0] v;
        int base;
        v = '0;
        base = (int'(a) / BLOCK_WORDS) * BLOCK_WORDS;
        for (int j = 0; j < BLOCK_WORDS; j++) begin
            if (ref_mem.exists(ADDR_W'(base + j))) v[j*WORD_W +: WORD_W] = ref_mem[ADDR_W'(base + j)];
        end
        return v;
    endfunction

    task automatic request(input logic [ADDR_W-1:0] a, input int drop,
                           input logic w, input logic [ADDR_W-1:0] wa, input logic [WORD_W-1:0] wd,
                           input logic mid_w, input int mid_at,
                           input logic [ADDR_W-1:0] ma, input logic [WORD_W-1:0] md);
        logic [WORD_W*BLOCK_WORDS-1:0] exp;
        int first;
        int nd;
        int bad;
        read = 1'b0; wr_en = 1'b0;
        step();
        read = 1'b1; addr = a; wr_en = w; wr_addr = wa; wr_data = wd;
        step();
        acc_edge = edge_cnt; acc_valid = 1;
        wr_en = 1'b0;
        exp = model_block(a);
        first = -1; nd = 0; bad = 0;
        if (busy !== 1'b1) bad++;
        for (int i = 1; i <= WATCH; i++) begin
            if (i == drop) read = 1'b0;
            if (mid_w && i == mid_at) begin
                wr_en = 1'b1; wr_addr = ma; wr_data = md;
            end else begin
                wr_en = 1'b0;
            end
            step();
            if (done === 1'b1) begin
                nd++;
                if (first < 0) first = i;
            end
            if (busy !== (i <= DONE_AT)) bad++;
        end
        read = 1'b0; wr_en = 1'b0;
        check("done_cycle", first, DONE_AT);
        check("done_count", nd, 1);
        check("busy_window", bad, 0);
        check("data_out", data_out, exp);
        acc_valid = 0;
    endtask

    logic [ADDR_W-1:0] pool [6];

    initial begin
        int nd;
        pool[0] = 15'h0040; pool[1] = 15'h1230; pool[2] = 15'h2000;
        pool[3] = 15'h3FF8; pool[4] = 15'h5550; pool[5] = 15'h7FFC;

        step(); step();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_data", data_out, '0);
        rst = 1'b0;
        step();

        for (int j = 0; j < 4; j++) write_word(15'h0100 + 15'(j), 32'hA0 + 32'(j));
        for (int j = 0; j < 4; j++) write_word(15'h0200 + 15'(j), 32'h5000 + 32'(j));
        for (int p = 0; p < 6; p++)
            for (int j = 0; j < 4; j++) write_word(pool[p] + 15'(j), $urandom);

        request(15'h0102, 2, 0, '0, '0, 0, 0, '0, '0);
        check("block_100", data_out, {32'hA3, 32'hA2, 32'hA1, 32'hA0});

        // read held high well past done: no retrigger
        request(15'h0100, WATCH + 1, 0, '0, '0, 0, 0, '0, '0);

        // write during busy is dropped
        request(15'h0100, 1, 0, '0, '0, 1, 3, 15'h0200, 32'hDEAD_BEEF);
        request(15'h0200, 1, 0, '0, '0, 0, 0, '0, '0);
        check("drop_write", data_out[31:0], 32'h0000_5000);

        // write on the acceptance edge is seen by the fetch
        request(15'h0201, 1, 1, 15'h0200, 32'hCAFE_0001, 0, 0, '0, '0);
        check("same_edge_write", data_out[31:0], 32'hCAFE_0001);

        // reset three cycles into a request
        read = 1'b0; step();
        read = 1'b1; addr = 15'h0100; step();
        step(); step();
        rst = 1'b1; step();
        check("midrst_busy", busy, 1'b0);
        check("midrst_data", data_out, '0);
        check("midrst_done", done, 1'b0);
        rst = 1'b0; read = 1'b0;
        nd = 0;
        for (int i = 0; i < WATCH; i++) begin
            step();
            if (done === 1'b1) nd++;
        end
        check("midrst_no_done", nd, 0);
        request(15'h0103, 1, 0, '0, '0, 0, 0, '0, '0);

        // top of the address space
        request(15'h7FFF, 1, 0, '0, '0, 0, 0, '0, '0);
        check("top_block", data_out, model_block(15'h7FFC));

        for (int it = 0; it < 20; it++) begin
            logic [ADDR_W-1:0] a;
            logic [ADDR_W-1:0] wa;
            logic [ADDR_W-1:0] ma;
            a  = pool[$urandom_range(5, 0)] + 15'($urandom_range(3, 0));
            wa = pool[$urandom_range(5, 0)] + 15'($urandom_range(3, 0));
            ma = pool[$urandom_range(5, 0)] + 15'($urandom_range(3, 0));
            request(a, $urandom_range(WATCH, 1),
                    1'($urandom_range(1, 0)), wa, $urandom,
                    1'($urandom_range(1, 0)), $urandom_range(WATCH, 1), ma, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
